// File: rtl/register_file_mp_if.sv
// rtl/register_file_mp_if.sv - read/write bus bundle for the multi-port register file
interface register_file_mp_if #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDRES      = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
);
    logic [READ_PORTS*ADDRES-1:0]     addres_read;
    logic [READ_PORTS*WORD_SIZE-1:0]  data_read;
    logic [WRITE_PORTS-1:0]           signal_we;
    logic [WRITE_PORTS*ADDRES-1:0]    addres_write;
    logic [WRITE_PORTS*WORD_SIZE-1:0] data_write;
    logic                             ready;
    logic                             conflict;

    modport master (
        output addres_read, signal_we, addres_write, data_write,
        input  data_read, ready, conflict
    );

    modport slave (
        input  addres_read, signal_we, addres_write, data_write,
        output data_read, ready, conflict
    );
endinterface

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with clear sweep; optional REGISTER_FILE_MP_BYPASS_EN
module register_file_mp #(
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH       = 32,
    parameter int ADDRES      = $clog2(DEPTH),
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int ZERO_REG    = 1
) (
    input  logic                clk,
    input  logic                rst,
    register_file_mp_if.slave   bus
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [ADDRES-1:0] CNT_LAST = ADDRES'(DEPTH - 1);

    logic [WORD_SIZE-1:0]           regs_q [DEPTH];
    state_t                         state_q;
    logic [ADDRES-1:0]              clear_cnt_q;
    logic                           ready_q;
    logic                           conflict_q;
    logic                           conflict_d;

    logic [ADDRES-1:0]              wr_addr [WRITE_PORTS];
    logic [WORD_SIZE-1:0]           wr_data [WRITE_PORTS];
    logic [ADDRES-1:0]              rd_addr [READ_PORTS];
    logic [WORD_SIZE-1:0]           rd_word [READ_PORTS];
    logic [READ_PORTS*WORD_SIZE-1:0] rd_flat;

    // An address is usable if it names a real register and is not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDRES-1:0] a);
        addr_ok = (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Split the packed bus fields into per-port views.
    always_comb begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wr_addr[p] = bus.addres_write[p*ADDRES +: ADDRES];
            wr_data[p] = bus.data_write[p*WORD_SIZE +: WORD_SIZE];
        end
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_addr[i] = bus.addres_read[i*ADDRES +: ADDRES];
        end
    end

    // Two or more effective writes to the same register in one cycle; dropped writes never collide.
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            for (int q = p + 1; q < WRITE_PORTS; q++) begin
                if (bus.signal_we[p] && bus.signal_we[q] &&
                    (wr_addr[p] == wr_addr[q]) && addr_ok(wr_addr[p])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Array update: sweep zeros while clearing, otherwise port writes with the highest port last so it wins.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            regs_q[clear_cnt_q] <= '0;
        end else begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (bus.signal_we[p] && addr_ok(wr_addr[p])) begin
                    regs_q[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    // Control FSM: clear sweep after reset, then run until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clear_cnt_q <= '0;
            ready_q     <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    conflict_q <= 1'b0;
                    if (clear_cnt_q == CNT_LAST) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        clear_cnt_q <= clear_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    conflict_q <= conflict_d;
                end
                default: begin
                    state_q     <= S_CLEAR;
                    clear_cnt_q <= '0;
                    ready_q     <= 1'b0;
                    conflict_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational reads; zero while clearing, for register 0 (when hardwired) and out of range.
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_word[i] = '0;
            if ((state_q == S_RUN) && addr_ok(rd_addr[i])) begin
                rd_word[i] = regs_q[rd_addr[i]];
`ifdef REGISTER_FILE_MP_BYPASS_EN
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (bus.signal_we[p] && (wr_addr[p] == rd_addr[i])) begin
                        rd_word[i] = wr_data[p];
                    end
                end
`endif
            end
        end
    end

    // Repack read data onto the bus.
    always_comb begin
        rd_flat = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_flat[i*WORD_SIZE +: WORD_SIZE] = rd_word[i];
        end
    end

    assign bus.data_read = rd_flat;
    assign bus.ready     = ready_q;
    assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp
module tb_register_file_mp;

    localparam int WS    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RP    = 2;
    localparam int WP    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    register_file_mp_if #(.WORD_SIZE(WS), .ADDRES(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

    register_file_mp #(
        .WORD_SIZE(WS), .DEPTH(DEPTH), .ADDRES(AW),
        .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          port;
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t sb[$];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        conf;
    } vec_t;

    vec_t vecs[8];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic expect_read(input int port, input logic [4:0] addr, input logic [31:0] exp,
                               input string name);
        rd_exp_t e;
        bus.addres_read[port*AW +: AW] = addr;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        rd_exp_t     e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = bus.data_read[e.port*WS +: WS];
            n_cmp++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic drive_write(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1);
        bus.signal_we    = we;
        bus.addres_write = {a1, a0};
        bus.data_write   = {d1, d0};
    endtask

    initial begin
        vecs[0] = '{2'b11, 5'd1, 32'hA1B1C1D1, 5'd2, 32'hA2B2C2D2, 5'd1, 5'd2, 32'hA1B1C1D1, 32'hA2B2C2D2, 1'b0};
        vecs[1] = '{2'b11, 5'd5, 32'h11111111, 5'd5, 32'h22222222, 5'd5, 5'd5, 32'h22222222, 32'h22222222, 1'b1};
        vecs[2] = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd9, 32'h0BADF00D, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[3] = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hEEEEEEEE, 5'd0, 5'd1, 32'h00000000, 32'hA1B1C1D1, 1'b0};
        vecs[4] = '{2'b10, 5'd1, 32'hDEADDEAD, 5'd7, 32'h77777777, 5'd7, 5'd2, 32'h77777777, 32'hA2B2C2D2, 1'b0};
        vecs[5] = '{2'b01, 5'd3, 32'h33333333, 5'd3, 32'hDEADDEAD, 5'd3, 5'd5, 32'h33333333, 32'h22222222, 1'b0};
        vecs[6] = '{2'b11, 5'd8, 32'h88888888, 5'd9, 32'h99999999, 5'd9, 5'd8, 32'h99999999, 32'h88888888, 1'b0};
        vecs[7] = '{2'b00, 5'd1, 32'h0, 5'd7, 32'h0, 5'd1, 5'd7, 32'hA1B1C1D1, 32'h77777777, 1'b0};

        rst = 1'b1;
        bus.addres_read = '0;
        drive_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset_ready", bus.ready, 1'b0);
        check_bit("reset_conflict", bus.conflict, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clear sweep: writes (same address on both ports) ignored, reads forced to zero.
        drive_write(2'b11, 5'd1, 32'hA1B1C1D1, 5'd1, 32'hA1B1C1D1);
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_bit($sformatf("clear_ready_%0d", k), bus.ready, (k == DEPTH));
            check_bit($sformatf("clear_conflict_%0d", k), bus.conflict, 1'b0);
            if (k < DEPTH) begin
                expect_read(0, 5'd1, 32'h0, $sformatf("clear_rd0_%0d", k));
                expect_read(1, 5'd1, 32'h0, $sformatf("clear_rd1_%0d", k));
                drain();
            end
        end
        drive_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        expect_read(0, 5'd1, 32'h0, "clear_write_dropped");
        #1;
        drain();

        // Table-driven write/read vectors.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive_write(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
            bus.addres_read = '0;
            @(negedge clk);
            check_bit($sformatf("vec%0d_conf_before", i), bus.conflict, 1'b0);
            @(posedge clk);
            #1;
            drive_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            expect_read(0, vecs[i].ra0, vecs[i].exp0, $sformatf("vec%0d_rd0", i));
            expect_read(1, vecs[i].ra1, vecs[i].exp1, $sformatf("vec%0d_rd1", i));
            @(negedge clk);
            drain();
            check_bit($sformatf("vec%0d_conf", i), bus.conflict, vecs[i].conf);
            @(posedge clk);
            #1;
        end

        // Same-cycle write and read of register 6; bypass of register 0 must still read zero.
        drive_write(2'b11, 5'd6, 32'hA3B3C3D3, 5'd0, 32'hFFFFFFFF);
`ifdef REGISTER_FILE_MP_BYPASS_EN
        expect_read(0, 5'd6, 32'hA3B3C3D3, "same_cycle_rd6");
`else
        expect_read(0, 5'd6, 32'h00000000, "same_cycle_rd6");
`endif
        expect_read(1, 5'd0, 32'h0, "same_cycle_rd0");
        @(negedge clk);
        drain();
        check_bit("same_cycle_conf_before", bus.conflict, 1'b0);
        @(posedge clk);
        #1;
        drive_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        expect_read(0, 5'd6, 32'hA3B3C3D3, "next_cycle_rd6");
        expect_read(1, 5'd0, 32'h0, "next_cycle_rd0");
        @(negedge clk);
        drain();
        check_bit("same_cycle_conf_after", bus.conflict, 1'b0);

        // Populate register 4, then reset mid-run and confirm a full re-clear.
        @(posedge clk);
        #1;
        drive_write(2'b10, 5'd0, 32'h0, 5'd4, 32'h44444444);
        @(posedge clk);
        #1;
        drive_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        expect_read(0, 5'd4, 32'h44444444, "pop_rd4");
        expect_read(1, 5'd5, 32'h22222222, "pop_rd5");
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_bit("midrun_ready_drop", bus.ready, 1'b0);
        expect_read(0, 5'd1, 32'h0, "midrun_rd1_forced");
        expect_read(1, 5'd4, 32'h0, "midrun_rd4_forced");
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == DEPTH - 1) check_bit("reclear_ready_low", bus.ready, 1'b0);
            if (k == DEPTH)     check_bit("reclear_ready_high", bus.ready, 1'b1);
        end
        for (int a = 0; a < DEPTH; a += 2) begin
            expect_read(0, 5'(a), 32'h0, $sformatf("reclear_rd%0d", a));
            expect_read(1, 5'(a + 1), 32'h0, $sformatf("reclear_rd%0d", a + 1));
            #1;
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
